mul_sched: RTL
==============

# mul_sched

Round-robin scheduler that shares one repeated-addition multiplier datapath (`mul_datapath`) among `N_REQ` requesters. It replaces `mul_controlpath` as the sole driver of the datapath strobes and owns the datapath's `data_in` bus. It arbitrates, loads the operands, runs the add/decrement loop until `eqz`, and returns the product with the winner's ID.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `WIDTH`, 16: operand/product width; matches the datapath.
- `ID_W`, `$clog2(N_REQ)`: width of `done_id`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: level request per requester.
- `a_in` in N_REQ*WIDTH: multiplicand, slice i = requester i.
- `b_in` in N_REQ*WIDTH: multiplier (iteration count), slice i.
- `gnt` out N_REQ: one-hot grant.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `done_id` out ID_W: requester served; valid with `done`.
- `result` out WIDTH: product; valid with `done`.
- `data_out` out WIDTH: drives datapath `data_in`.
- `ldA`, `ldB`, `ldP`, `clrP`, `decB` out 1 each: datapath strobes.
- `eqz` in 1: datapath B==0 flag.
- `Y` in WIDTH: datapath product register P.

## Operation
- Datapath contract:
  - `ldA`: A<=data_in.
  - `ldB`: B<=data_in.
  - `clrP`: P<=0.
  - `ldP`: P<=P+A.
  - `decB`: B<=B-1.
  - `eqz` is combinational from B.
- FSM states: IDLE, LOAD_A, LOAD_B, ADD, DONE.
- **IDLE**
  - All strobes are 0.
  - If any `req` bit is set, pick the winner: the first set bit at or after `ptr`, wrapping. Register it as `id`.
  - Go to LOAD_A. With no request, stay in IDLE.
- **LOAD_A**: `data_out`=a_in[id], `ldA`=1. Go to LOAD_B.
- **LOAD_B**: `data_out`=b_in[id], `ldB`=1, `clrP`=1. Go to ADD.
- **ADD**
  - If `eqz`: no strobes; go to DONE.
  - Otherwise: `ldP`=1 and `decB`=1 in the same cycle; stay in ADD.
- **DONE**
  - `done`=1, `done_id`=id, `result`=Y.
  - `ptr`<=id+1, wrapping modulo N_REQ.
  - Go to IDLE.
- `gnt[id]`=1 and `busy`=1 from LOAD_A through DONE inclusive. Both are 0 in IDLE.
- `data_out` is 0 outside LOAD_A/LOAD_B.
- Arithmetic: `result` = (A·B) mod 2^WIDTH. Overflow is silently truncated; there is no flag.
- Boundary conditions:
  - B=0 gives `result`=0 with zero additions.
  - A=0 gives `result`=0 after B iterations.
  - `req` is sampled only in IDLE. Changes to `req` or operands after LOAD_B are ignored. A deasserted `req` mid-operation does not abort; `done` still pulses.
  - A requester must hold its operands stable from its request through LOAD_B. It drops `req` at the clock edge that ends its `done` cycle.
  - Simultaneous requests: round-robin from `ptr`. No requester waits more than N_REQ-1 operations.

## Timing
- Request seen in IDLE at cycle 0:
  - LOAD_A at cycle 1.
  - LOAD_B at cycle 2.
  - ADD at cycles 3 … 3+B.
  - DONE at cycle 4+B.
- Latency from request to `done` is B+4 cycles. A back-to-back grant can start no earlier than 1 cycle after DONE (one IDLE cycle).
- Reset values (all outputs registered or decoded from registered state):
  - `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `result`=0, `data_out`=0.
  - All strobes 0.
  - `ptr`=0; state IDLE.
- Reset mid-operation: return to IDLE on the next edge and abandon the operation with no `done`. Datapath registers are left as-is; the next LOAD_B clears P.

## Structure
- Package `mul_sched_pkg`:
  - state enum.
  - reset-value localparams.
- Sub-module `rr_arbiter`:
  - combinational.
  - inputs `req` and `ptr`.
  - outputs one-hot `grant`, `grant_id`, and `any`.
  - used by IDLE.
- Top level: FSM, `id`/`ptr` registers, operand mux, and `result` register.

## Test plan
- Single request: req[0], A=17, B=5 → gnt=0001; done at cycle 9 after the request; result=85; done_id=0; exactly 5 `ldP`/`decB` pulses.
- B=0: req[2], A=1234, B=0 → done at cycle 4; result=0; no `ldP` pulses.
- Fairness: req=1111 held continuously, ptr=0 → grant order 0,1,2,3,0, each with the correct product.
- Overflow: A=16'hFFFF, B=3 → result=16'hFFFD.
- Mid-operation `rst` during ADD (A=10, B=8) → next cycle: state IDLE, all outputs 0, no done. A fresh request then completes with the correct product.
- `req` dropped during ADD → done still pulses with the correct product; ptr advances.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and reset values for the round-robin multiplier scheduler.
// The FSM walks IDLE -> LOAD_A -> LOAD_B -> ADD* -> DONE once per operation.
package mul_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_ADD    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam state_t STATE_RST = S_IDLE;
    localparam int     PTR_RST   = 0;
    localparam int     ID_RST    = 0;
    localparam int     RESULT_RST = 0;

endpackage

// File: rtl/mul_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);

    int idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!any && req[idx]) begin
                any         = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_sched.sv
// Shares one repeated-addition multiplier datapath among N_REQ requesters,
// driving its strobes and data_in bus and returning the product with the winner's ID.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [WIDTH-1:0]       result,
    output logic [WIDTH-1:0]       data_out,
    output logic                   ldA,
    output logic                   ldB,
    output logic                   ldP,
    output logic                   clrP,
    output logic                   decB,
    input  logic                   eqz,
    input  logic [WIDTH-1:0]       Y
);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [N_REQ-1:0]   arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;
    logic [WIDTH-1:0]   a_sel, b_sel;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req      (req),
        .ptr      (ptr_q),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    assign a_sel = a_in[int'(id_q)*WIDTH +: WIDTH];
    assign b_sel = b_in[int'(id_q)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STATE_RST;
            id_q     <= ID_W'(ID_RST);
            ptr_q    <= ID_W'(PTR_RST);
            gnt_q    <= '0;
            result_q <= WIDTH'(RESULT_RST);
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        result_d = result_q;
        data_out = '0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        ldP      = 1'b0;
        clrP     = 1'b0;
        decB     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    id_d    = arb_id;
                    gnt_d   = arb_grant;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                data_out = a_sel;
                ldA      = 1'b1;
                state_d  = S_LOAD_B;
            end
            S_LOAD_B: begin
                data_out = b_sel;
                ldB      = 1'b1;
                clrP     = 1'b1;
                state_d  = S_ADD;
            end
            S_ADD: begin
                // P is final once B hits zero; capture it so result is registered in DONE
                if (eqz) begin
                    result_d = Y;
                    state_d  = S_DONE;
                end else begin
                    ldP  = 1'b1;
                    decB = 1'b1;
                end
            end
            S_DONE: begin
                ptr_d   = (int'(id_q) == N_REQ-1) ? '0 : id_q + ID_W'(1);
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign gnt     = busy ? gnt_q : '0;
    assign done    = (state_q == S_DONE);
    assign done_id = done ? id_q : '0;
    assign result  = done ? result_q : '0;

endmodule
